// File: rtl/io_input_conditioner.sv
// Board input conditioner: synchroniser, per-channel debounce, edge pulses,
// sticky write-1-to-clear event register and a masked, registered interrupt.
module io_input_conditioner #(
    parameter int unsigned       NUM_CH          = 32,
    parameter int unsigned       SYNC_STAGES     = 2,
    parameter int unsigned       DEBOUNCE_CYCLES = 16,
    parameter logic [NUM_CH-1:0] RESET_VAL       = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_CH-1:0] raw_i,
    input  logic              tick_i,
    output logic [NUM_CH-1:0] level_o,
    output logic [NUM_CH-1:0] rise_o,
    output logic [NUM_CH-1:0] fall_o,
    output logic [NUM_CH-1:0] event_o,
    input  logic              clr_en_i,
    input  logic [NUM_CH-1:0] clr_i,
    input  logic [NUM_CH-1:0] irq_mask_i,
    output logic              irq_o
);

    localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [CW-1:0]     cnt_q  [NUM_CH];
    logic [CW-1:0]     cnt_d  [NUM_CH];
    logic [NUM_CH-1:0] level_q, level_d;
    logic [NUM_CH-1:0] rise_q, rise_d;
    logic [NUM_CH-1:0] fall_q, fall_d;
    logic [NUM_CH-1:0] event_q, event_d;
    logic              irq_q;
    logic [NUM_CH-1:0] stable;

    assign stable = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < int'(SYNC_STAGES); k++) sync_q[k] <= RESET_VAL;
        end else begin
            sync_q[0] <= raw_i;
            for (int k = 1; k < int'(SYNC_STAGES); k++) sync_q[k] <= sync_q[k-1];
        end
    end

    // The counter only advances on ticks while the synchronised input
    // disagrees with the accepted level; any agreement discards progress.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (stable[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick_i) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = ~level_q[i];
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
        rise_d  = level_d & ~level_q;
        fall_d  = ~level_d & level_q;
        // A new edge wins over a simultaneous clear of the same bit.
        event_d = (event_q & ~(clr_i & {NUM_CH{clr_en_i}})) | rise_d | fall_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NUM_CH); i++) cnt_q[i] <= '0;
            level_q <= RESET_VAL;
            rise_q  <= '0;
            fall_q  <= '0;
            event_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            event_q <= event_d;
            irq_q   <= |(event_q & irq_mask_i);
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign event_o = event_q;
    assign irq_o   = irq_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Bench for io_input_conditioner: constant vector table, directed corner
// sequences and random traffic checked every cycle against a reference model.
module tb_io_input_conditioner;

    localparam int SYNC = 2;
    localparam int DEB  = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] raw;
    logic        tick;
    logic [31:0] level, rise, fall, evt;
    logic        clr_en;
    logic [31:0] clr;
    logic [31:0] mask;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    io_input_conditioner #(
        .NUM_CH(32), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .RESET_VAL(32'h0)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .raw_i(raw), .tick_i(tick),
        .level_o(level), .rise_o(rise), .fall_o(fall), .event_o(evt),
        .clr_en_i(clr_en), .clr_i(clr), .irq_mask_i(mask), .irq_o(irq)
    );

    always #5 clk = ~clk;

    // Reference model: delay line of raw samples, plus a count of consecutive
    // disagreeing ticks per channel; a channel flips when that count hits DEB.
    logic [31:0] m_sync[$];
    int          m_run[32];
    logic [31:0] m_level, m_rise, m_fall, m_event;
    logic        m_irq;

    task automatic model_reset();
        m_sync.delete();
        for (int k = 0; k < SYNC; k++) m_sync.push_back(32'h0);
        for (int c = 0; c < 32; c++) m_run[c] = 0;
        m_level = 0; m_rise = 0; m_fall = 0; m_event = 0; m_irq = 0;
    endtask

    task automatic model_update();
        logic [31:0] s, nl;
        s = m_sync[0];
        void'(m_sync.pop_front());
        m_sync.push_back(raw);
        m_irq = |(m_event & mask);
        nl = m_level;
        for (int c = 0; c < 32; c++) begin
            if (s[c] != m_level[c]) begin
                if (tick) begin
                    m_run[c] = m_run[c] + 1;
                    if (m_run[c] == DEB) begin
                        nl[c] = ~m_level[c];
                        m_run[c] = 0;
                    end
                end
            end else begin
                m_run[c] = 0;
            end
        end
        m_rise  = nl & ~m_level;
        m_fall  = ~nl & m_level;
        m_event = (m_event & ~(clr & {32{clr_en}})) | m_rise | m_fall;
        m_level = nl;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("level", level, m_level);
        chk("rise", rise, m_rise);
        chk("fall", fall, m_fall);
        chk("event", evt, m_event);
        chk("irq", {31'h0, irq}, {31'h0, m_irq});
        chk("rise_and_fall", rise & fall, 32'h0);
    endtask

    typedef struct {
        logic [31:0] raw;
        logic        clr_all;
        int          cycles;
        logic [31:0] exp_level;
        logic [31:0] exp_rise;
        logic [31:0] exp_fall;
        logic [31:0] exp_event;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int k_lvl;
        vecs[0] = '{32'h0002_ABCD, 1'b0, 17, 32'h0,         32'h0,         32'h0,         32'h0};
        vecs[1] = '{32'h0002_ABCD, 1'b0, 1,  32'h0002_ABCD, 32'h0002_ABCD, 32'h0,         32'h0002_ABCD};
        vecs[2] = '{32'h0002_ABCD, 1'b1, 1,  32'h0002_ABCD, 32'h0,         32'h0,         32'h0};
        vecs[3] = '{32'h0,         1'b0, 17, 32'h0002_ABCD, 32'h0,         32'h0,         32'h0};
        vecs[4] = '{32'h0,         1'b1, 1,  32'h0,         32'h0,         32'h0002_ABCD, 32'h0002_ABCD};
        vecs[5] = '{32'h0,         1'b1, 1,  32'h0,         32'h0,         32'h0,         32'h0};
        vecs[6] = '{32'h1,         1'b0, 15, 32'h0,         32'h0,         32'h0,         32'h0};
        vecs[7] = '{32'h0,         1'b0, 20, 32'h0,         32'h0,         32'h0,         32'h0};

        // Reset with a non-reset value already on the inputs
        rst_n = 1'b0; raw = 32'h0002_ABCD; tick = 1'b1;
        clr_en = 1'b0; clr = 32'h0; mask = 32'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_level", level, 32'h0);
        chk("reset_rise", rise, 32'h0);
        chk("reset_fall", fall, 32'h0);
        chk("reset_event", evt, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        rst_n = 1'b1;

        // Reset release, clear races and glitch rejection from the table
        foreach (vecs[v]) begin
            raw = vecs[v].raw; clr_en = vecs[v].clr_all; clr = 32'hFFFF_FFFF;
            repeat (vecs[v].cycles) step();
            chk($sformatf("vec%0d_level", v), level, vecs[v].exp_level);
            chk($sformatf("vec%0d_rise", v), rise, vecs[v].exp_rise);
            chk($sformatf("vec%0d_fall", v), fall, vecs[v].exp_fall);
            chk($sformatf("vec%0d_event", v), evt, vecs[v].exp_event);
        end
        clr_en = 1'b0; clr = 32'h0;

        // Edge on channel 17 with interrupt enabled
        mask = 32'h0002_0000; raw = 32'h0002_0000;
        repeat (17) step();
        chk("edge17_early", rise & 32'h0002_0000, 32'h0);
        step();
        chk("edge17_rise", rise, 32'h0002_0000);
        chk("edge17_event", evt & 32'h0002_0000, 32'h0002_0000);
        chk("edge17_irq_lag", {31'h0, irq}, 32'h0);
        step();
        chk("edge17_irq", {31'h0, irq}, 32'h1);
        chk("edge17_pulse_end", rise, 32'h0);

        // Clear racing a fall on channel 3
        clr_en = 1'b1; clr = 32'hFFFF_FFFF; mask = 32'h0000_0008;
        step();
        clr_en = 1'b0; clr = 32'h0;
        raw = 32'h0002_0008;
        repeat (20) step();
        clr_en = 1'b1; clr = 32'hFFFF_FFFF;
        step();
        clr_en = 1'b0; clr = 32'h0;
        step();
        raw = 32'h0002_0000;
        repeat (17) step();
        clr_en = 1'b1; clr = 32'h0000_0008;
        step();
        chk("race_fall3", fall, 32'h0000_0008);
        chk("race_event3", evt & 32'h8, 32'h8);
        step();
        chk("race_cleared3", evt & 32'h8, 32'h0);
        chk("race_irq_held", {31'h0, irq}, 32'h1);
        clr_en = 1'b0; clr = 32'h0;
        step();
        chk("race_irq_drop", {31'h0, irq}, 32'h0);

        // tick_i every 4th cycle on channel 5
        raw = 32'h0002_0020;
        k_lvl = -1;
        for (int k = 1; k <= 200 && k_lvl < 0; k++) begin
            tick = (k % 4 == 0);
            step();
            if (level[5]) k_lvl = k;
        end
        tick = 1'b1;
        n_cmp++;
        if (k_lvl < 0 || (k_lvl - SYNC) < 60 || (k_lvl - SYNC) > 68) begin
            n_err++;
            $display("FAIL tick_gating: got %0d cycles after sync expected 60..68", k_lvl - SYNC);
        end

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < 32; c++)
                if ($urandom_range(0, 39) == 0) raw[c] = ~raw[c];
            tick   = ($urandom_range(0, 3) != 0);
            clr_en = ($urandom_range(0, 7) == 0);
            clr    = $urandom;
            if ($urandom_range(0, 15) == 0) mask = $urandom;
            step();
        end

        // Async reset while channel 9 is mid-debounce
        tick = 1'b1; clr_en = 1'b0; clr = 32'h0;
        raw = m_level;
        repeat (20) step();
        raw = m_level ^ 32'h0000_0200;
        repeat (SYNC + 10) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_level", level, 32'h0);
        chk("midreset_rise", rise, 32'h0);
        chk("midreset_fall", fall, 32'h0);
        chk("midreset_event", evt, 32'h0);
        chk("midreset_irq", {31'h0, irq}, 32'h0);
        model_reset();
        raw = 32'h0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 30; n++) begin
            step();
            chk("post_reset_edges", rise | fall, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
